// File: rtl/alu_ctl_sequencer.sv
// rtl/alu_ctl_sequencer.sv - registered RISC-V ALU control decoder with valid/ready output and RV32M occupancy tracking
module alu_ctl_sequencer #(
    parameter int CTL_W    = 8,
    parameter int ENABLE_M = 1,
    parameter int MUL_LAT  = 3,
    parameter int DIV_LAT  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             funct7_b5,
    input  logic             funct7_b0,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CTL_W-1:0] alu_ctl,
    output logic             illegal,
    output logic             busy,
    output logic             mc_done
);

    typedef enum logic [1:0] {IDLE, HOLD, BUSY} state_t;

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);

    state_t           state, state_d;
    logic [CTL_W-1:0] ctl_q;
    logic             ill_q;
    logic             mop_q;
    logic             div_q;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       dec_ctl;
    logic             dec_ill;
    logic             dec_mop;
    logic             accept;
    logic             load_cnt;

    // Decode the instruction fields into the 8-bit control word
    always_comb begin
        dec_ctl = 8'h0F;
        dec_ill = 1'b0;
        dec_mop = 1'b0;
        case (opcode)
            7'b0110111, 7'b0010111: dec_ctl = 8'h02;
            7'b1101111, 7'b1100111: dec_ctl = 8'h0F;
            7'b1100011: begin
                case (funct3)
                    3'b000:  dec_ctl = 8'h16;
                    3'b001:  dec_ctl = 8'h26;
                    3'b100:  dec_ctl = 8'h36;
                    3'b101:  dec_ctl = 8'h46;
                    3'b110:  dec_ctl = 8'h56;
                    3'b111:  dec_ctl = 8'h66;
                    default: dec_ill = 1'b1;
                endcase
            end
            7'b0000011: begin
                case (funct3)
                    3'b000, 3'b001, 3'b010, 3'b100, 3'b101: dec_ctl = 8'h02;
                    default: dec_ill = 1'b1;
                endcase
            end
            7'b0100011: begin
                case (funct3)
                    3'b000, 3'b001, 3'b010: dec_ctl = 8'h02;
                    default: dec_ill = 1'b1;
                endcase
            end
            7'b0010011: begin
                case (funct3)
                    3'b000:         dec_ctl = 8'h02;
                    3'b001:         dec_ctl = 8'h05;
                    3'b010, 3'b011: dec_ctl = 8'h07;
                    3'b100:         dec_ctl = 8'h08;
                    3'b101:         dec_ctl = funct7_b5 ? 8'h04 : 8'h03;
                    3'b110:         dec_ctl = 8'h01;
                    default:        dec_ctl = 8'h00;
                endcase
            end
            7'b0110011: begin
                if (funct7_b0) begin
                    if (ENABLE_M != 0) begin
                        dec_ctl = {1'b1, 4'b0000, funct3};
                        dec_mop = 1'b1;
                    end else begin
                        dec_ill = 1'b1;
                    end
                end else begin
                    case (funct3)
                        3'b000:         dec_ctl = funct7_b5 ? 8'h06 : 8'h02;
                        3'b001:         dec_ctl = 8'h05;
                        3'b010, 3'b011: dec_ctl = 8'h07;
                        3'b100:         dec_ctl = 8'h08;
                        3'b101:         dec_ctl = funct7_b5 ? 8'h04 : 8'h03;
                        3'b110:         dec_ctl = 8'h01;
                        default:        dec_ctl = 8'h00;
                    endcase
                end
            end
            7'b1110011: begin
                case (funct3[1:0])
                    2'b01:   dec_ctl = 8'h09;
                    2'b10:   dec_ctl = 8'h0A;
                    2'b11:   dec_ctl = 8'h0B;
                    default: dec_ctl = 8'h0F;
                endcase
            end
            default: dec_ill = 1'b1;
        endcase
    end

    // Handshake, next state and status outputs
    always_comb begin
        state_d   = state;
        load_cnt  = 1'b0;
        in_ready  = (state == IDLE) || ((state == HOLD) && out_ready && !mop_q);
        accept    = in_valid && in_ready;
        out_valid = (state == HOLD);
        busy      = (state == BUSY);
        mc_done   = (state == BUSY) && (cnt == '0);
        case (state)
            IDLE: begin
                if (accept) state_d = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    if (mop_q) begin
                        state_d  = BUSY;
                        load_cnt = 1'b1;
                    end else if (!accept) begin
                        state_d = IDLE;
                    end
                end
            end
            BUSY: begin
                if (cnt == '0) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    // Capture the decoded word on every accepted instruction
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctl_q <= '0;
            ill_q <= 1'b0;
            mop_q <= 1'b0;
            div_q <= 1'b0;
        end else if (accept) begin
            ctl_q <= CTL_W'(dec_ctl);
            ill_q <= dec_ill;
            mop_q <= dec_mop;
            div_q <= funct3[2];
        end
    end

    // Multi-cycle occupancy counter: loads LAT-1 on issue, counts down to zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load_cnt) begin
            cnt <= div_q ? DIV_LOAD : MUL_LOAD;
        end else if ((state == BUSY) && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign alu_ctl = ctl_q;
    assign illegal = ill_q;

endmodule

// File: doc/alu_ctl_sequencer.md
Name: alu_ctl_sequencer

Overview:
- Parametrised, registered successor to the combinational RISC-V ALU control decoder. Decodes opcode/funct fields into the existing ALU control word and presents it through a one-entry valid/ready output stage.
- Adds RV32M decode and multi-cycle occupancy tracking: a busy interval after each MUL/DIV issue, then a done pulse.
- Sits between the decode stage and the ALU/multiply-divide unit.

Parameters:
- CTL_W, 8: control word width; must be ≥8. Bits [6:4] = branch condition, [3:0] = ALU op, [7] = M-extension flag, [CTL_W-1:8] = zero.
- ENABLE_M, 1: 1 = decode RV32M; 0 = M-ops decode as illegal.
- MUL_LAT, 3: busy cycles after a MUL/MULH/MULHSU/MULHU issue; must be ≥1.
- DIV_LAT, 32: busy cycles after a DIV/DIVU/REM/REMU issue; must be ≥1.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  decode fields valid
- in_ready  out  1  block can accept fields
- opcode  in  7  instruction[6:0]
- funct3  in  3  instruction[14:12]
- funct7_b5  in  1  instruction[30] (SUB/SRA/SRAI)
- funct7_b0  in  1  instruction[25] (M-extension select when opcode=0110011)
- out_valid  out  1  alu_ctl valid
- out_ready  in  1  consumer accepts alu_ctl
- alu_ctl  out  CTL_W  control word
- illegal  out  1  qualifies out_valid: no legal decode
- busy  out  1  multi-cycle op in flight
- mc_done  out  1  one-cycle pulse when busy deasserts

Behaviour:
- Reset, async, all outputs low: alu_ctl=0, out_valid=0, illegal=0, busy=0, mc_done=0, state=IDLE, counter=0. in_ready is combinational and reads 1 after reset.

Decode (low 7 bits; upper bits zero unless stated):
- LUI 0110111 and AUIPC 0010111: 0x02.
- JAL 1101111 and JALR 1100111: 0x0F.
- Branch 1100011, by funct3:
  - 000 → 0x16; 001 → 0x26; 100 → 0x36; 101 → 0x46; 110 → 0x56; 111 → 0x66.
  - other funct3 → 0x0F, illegal.
- Load 0000011: funct3 ∈ {000,001,010,100,101} → 0x02; else 0x0F, illegal.
- Store 0100011: funct3 ∈ {000,001,010} → 0x02; else 0x0F, illegal.
- OP-IMM 0010011, by funct3:
  - 000 → 0x02; 010/011 → 0x07; 100 → 0x08; 110 → 0x01; 111 → 0x00; 001 → 0x05.
  - 101 → 0x03 if funct7_b5=0, else 0x04.
- OP 0110011 with funct7_b0=0, by funct3:
  - 000 → 0x02 (funct7_b5=0) or 0x06 (funct7_b5=1).
  - 001 → 0x05; 010/011 → 0x07; 100 → 0x08; 101 → 0x03/0x04 by funct7_b5; 110 → 0x01; 111 → 0x00.
- OP 0110011 with funct7_b0=1 and ENABLE_M=1: alu_ctl = {zeros, bit7=1, 0000, funct3}. This is an M-op.
- OP 0110011 with funct7_b0=1 and ENABLE_M=0: 0x0F, illegal.
- SYSTEM 1110011, by funct3[1:0]: 01 → 0x09; 10 → 0x0A; 11 → 0x0B; 00 → 0x0F (not illegal).
- Any other opcode: 0x0F, illegal.

FSM states: IDLE, HOLD, BUSY.
- in_ready = (state==IDLE) | (state==HOLD & out_ready & ~held_is_mop).
- Accept = in_valid & in_ready.
- Decoded word, illegal flag and is_mop are registered on accept; out_valid rises the next cycle. Latency is 1 cycle.
- IDLE: on accept → HOLD.
- HOLD:
  - out_valid=1; alu_ctl and illegal stay stable until out_ready.
  - On out_ready with non-M-op: accept in the same cycle → HOLD with new word; otherwise → IDLE.
  - On out_ready with M-op: → BUSY. Counter loads LAT-1, where LAT = DIV_LAT if funct3[2]=1, else MUL_LAT.
- BUSY:
  - busy=1, out_valid=0, in_ready=0.
  - Counter decrements each cycle. At counter==0 → IDLE and mc_done=1 for that transition cycle, so busy lasts exactly LAT cycles.
- An illegal word still completes the HOLD handshake and never enters BUSY.
- Counter width: $clog2(max(MUL_LAT,DIV_LAT)+1).
- in_valid while in_ready=0 is ignored and not latched. The producer holds its fields.
- Reset asserted in any state (including mid-BUSY) → immediately IDLE, and no mc_done pulse.

Test Plan:
- Reset, then ADDI (0010011/000) with out_ready=1 → out_valid the next cycle with alu_ctl=0x02, illegal=0. A back-to-back ADD then SUB (funct7_b5=1) yields 0x02 then 0x06 on consecutive cycles.
- BGEU (1100011/111) with out_ready=0 for 4 cycles → alu_ctl holds 0x66, out_valid=1, in_ready=0 throughout. Release out_ready → handshake, then IDLE.
- MUL (0110011/000, funct7_b0=1), MUL_LAT=3 → alu_ctl=0x80. After the handshake busy=1 for exactly 3 cycles, mc_done pulses once, in_ready=0 during busy.
- DIVU (funct3=101), DIV_LAT=32 → alu_ctl=0x85 and busy for 32 cycles. Assert rst on busy cycle 10 → busy=0, out_valid=0, no mc_done. The next ADDI is accepted immediately.
- Opcode 1111111 → alu_ctl=0x0F, illegal=1, no BUSY entry. With ENABLE_M=0, MUL → 0x0F with illegal=1.
- CSRRS (1110011/010) → 0x0A, illegal=0. ECALL (funct3=000) → 0x0F, illegal=0.
